// File: rtl/mem_port_arbiter.sv
// Arbitrates one asynchronous single-port SRAM between fetch and data ports.
// Sequences multi-cycle SRAM timing and stalls the pipeline until done.
module mem_port_arbiter #(
  parameter int ADDR_W      = 20,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_ce,
  input  logic [31:0]       if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_ready,
  input  logic              mem_oe,
  input  logic              mem_we,
  input  logic [31:0]       mem_addr,
  input  logic [31:0]       mem_wdata,
  input  logic [3:0]        mem_be,
  output logic [31:0]       mem_rdata,
  output logic              mem_ready,
  output logic              stall,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [31:0]       sram_wdata,
  input  logic [31:0]       sram_rdata,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [3:0]        sram_be_n
);

  typedef enum logic [1:0] {
    IDLE,
    D_ACC,
    I_ACC,
    DONE
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(WAIT_CYCLES);

  state_t     state;
  logic [3:0] cnt;
  logic       fair;
  logic       is_wr;
  logic       serve_d;

  logic mem_req;
  logic grant_d;
  logic grant_i;

  assign mem_req = mem_oe | mem_we;
  assign grant_d = mem_req & (~if_ce | ~fair);
  assign grant_i = if_ce & ~grant_d;

  assign stall = (if_ce & ~if_ready) | (mem_req & ~mem_ready);

  // Address bits outside the SRAM word range are intentionally dropped.
  logic unused;
  assign unused = ^{if_addr[31:ADDR_W+2], if_addr[1:0],
                    mem_addr[31:ADDR_W+2], mem_addr[1:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      fair       <= 1'b0;
      is_wr      <= 1'b0;
      serve_d    <= 1'b0;
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_be_n  <= 4'hF;
      sram_addr  <= '0;
      sram_wdata <= '0;
      if_rdata   <= '0;
      mem_rdata  <= '0;
      if_ready   <= 1'b0;
      mem_ready  <= 1'b0;
    end else begin
      if_ready  <= 1'b0;
      mem_ready <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_d) begin
            state      <= D_ACC;
            serve_d    <= 1'b1;
            is_wr      <= mem_we;
            cnt        <= WAIT_INIT;
            sram_addr  <= mem_addr[ADDR_W+1:2];
            sram_wdata <= mem_wdata;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= mem_we;
            sram_we_n  <= ~mem_we;
            sram_be_n  <= mem_we ? ~mem_be : 4'h0;
          end else if (grant_i) begin
            state      <= I_ACC;
            serve_d    <= 1'b0;
            is_wr      <= 1'b0;
            fair       <= 1'b0;
            cnt        <= WAIT_INIT;
            sram_addr  <= if_addr[ADDR_W+1:2];
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b0;
            sram_we_n  <= 1'b1;
            sram_be_n  <= 4'h0;
          end
        end
        D_ACC, I_ACC: begin
          if (cnt == 4'd0) begin
            state     <= DONE;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_be_n <= 4'hF;
            if_ready  <= (state == I_ACC);
            mem_ready <= (state == D_ACC);
            if (!is_wr) begin
              if (state == I_ACC) if_rdata <= sram_rdata;
              else mem_rdata <= sram_rdata;
            end
          end else begin
            cnt <= cnt - 4'd1;
            // Release write strobe one cycle early for data hold.
            if (cnt == 4'd1) sram_we_n <= 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          if (serve_d && if_ce) fair <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
